// File: rtl/prbs_pkg.sv
// Shared PRBS constants: polynomial encodings, tap/length masks, FSM states.
// Used by the generator and the matching checker.
package prbs_pkg;

  typedef enum logic [1:0] {
    POLY_PRBS7  = 2'd0,
    POLY_PRBS15 = 2'd1,
    POLY_PRBS23 = 2'd2,
    POLY_PRBS31 = 2'd3
  } poly_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } state_e;

  localparam int SW = 31;

  localparam int TAP_N7  = 7;
  localparam int TAP_M7  = 6;
  localparam int TAP_N15 = 15;
  localparam int TAP_M15 = 14;
  localparam int TAP_N23 = 23;
  localparam int TAP_M23 = 18;
  localparam int TAP_N31 = 31;
  localparam int TAP_M31 = 28;

  localparam logic [SW-1:0] LEN7  =
    (31'd1 << TAP_N7) - 31'd1;
  localparam logic [SW-1:0] LEN15 =
    (31'd1 << TAP_N15) - 31'd1;
  localparam logic [SW-1:0] LEN23 =
    (31'd1 << TAP_N23) - 31'd1;
  localparam logic [SW-1:0] LEN31 =
    {SW{1'b1}};

  localparam logic [SW-1:0] TAP7  =
    (31'd1 << (TAP_N7 - 1)) |
    (31'd1 << (TAP_M7 - 1));
  localparam logic [SW-1:0] TAP15 =
    (31'd1 << (TAP_N15 - 1)) |
    (31'd1 << (TAP_M15 - 1));
  localparam logic [SW-1:0] TAP23 =
    (31'd1 << (TAP_N23 - 1)) |
    (31'd1 << (TAP_M23 - 1));
  localparam logic [SW-1:0] TAP31 =
    (31'd1 << (TAP_N31 - 1)) |
    (31'd1 << (TAP_M31 - 1));

  function automatic logic [SW-1:0] len_mask(
    input logic [1:0] p
  );
    logic [SW-1:0] m;
    m = LEN31;
    unique case (p)
      POLY_PRBS7:  m = LEN7;
      POLY_PRBS15: m = LEN15;
      POLY_PRBS23: m = LEN23;
      POLY_PRBS31: m = LEN31;
    endcase
    return m;
  endfunction

  function automatic logic [SW-1:0] tap_mask(
    input logic [1:0] p
  );
    logic [SW-1:0] m;
    m = TAP31;
    unique case (p)
      POLY_PRBS7:  m = TAP7;
      POLY_PRBS15: m = TAP15;
      POLY_PRBS23: m = TAP23;
      POLY_PRBS31: m = TAP31;
    endcase
    return m;
  endfunction

  // An all-zero register would lock the LFSR, so substitute 1.
  function automatic logic [SW-1:0] seed_fix(
    input logic [SW-1:0] v,
    input logic [1:0]    p
  );
    logic [SW-1:0] m;
    m = v & len_mask(p);
    if (m == '0) m = 31'd1;
    return m;
  endfunction

endpackage

// File: rtl/prbs_gen_multi_wide_step.sv
// Combinational WIDTH-step PRBS advance, MSB-first word.
// Shared between the generator and the checker.
module prbs_wide_step
  import prbs_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [SW-1:0]    state_i,
  input  logic [1:0]       poly_i,
  output logic [SW-1:0]    state_o,
  output logic [WIDTH-1:0] word_o
);

  logic [SW-1:0] msk;
  logic [SW-1:0] tap;
  logic [SW-1:0] st;
  logic          fb;

  always_comb begin
    msk    = len_mask(poly_i);
    tap    = tap_mask(poly_i);
    st     = state_i & msk;
    fb     = 1'b0;
    word_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      fb = ^(st & tap);
      st = {st[SW-2:0], fb} & msk;
      word_o[WIDTH-1-i] = fb;
    end
    state_o = st;
  end

endmodule

// File: rtl/prbs_gen_multi.sv
// Runtime-selectable PRBS7/15/23/31 word source with valid/ready.
// Optional data[0] error injection with PRBS_ERR_INJ_EN.
module prbs_gen_multi
  import prbs_pkg::*;
#(
  parameter int         WIDTH        = 32,
  parameter logic [1:0] POLY_DEFAULT = 2'd3,
  parameter logic [30:0] SEED_DEFAULT =
    31'h7FFF_FFFF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [1:0]       poly_sel,
  input  logic             seed_load,
  input  logic [30:0]      seed,
  input  logic             invert,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic [31:0]      word_cnt
`ifdef PRBS_ERR_INJ_EN
  ,
  input  logic             err_inject,
  output logic [15:0]      err_cnt
`endif
);

  localparam logic [SW-1:0] S_RST =
    SEED_DEFAULT & len_mask(POLY_DEFAULT);

  state_e           state_q, state_d;
  logic [SW-1:0]    s_q, s_d;
  logic [1:0]       poly_q, poly_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [31:0]      cnt_q, cnt_d;

  logic [SW-1:0]    s_step;
  logic [WIDTH-1:0] word_step;
  logic             load;
  logic             flip;

  prbs_wide_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .state_i (s_q),
    .poly_i  (poly_q),
    .state_o (s_step),
    .word_o  (word_step)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    poly_d  = poly_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    if (seed_load) begin
      s_d     = seed_fix(seed, poly_sel);
      poly_d  = poly_sel;
      cnt_d   = '0;
      state_d = en ? FILL : IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (en) begin
            poly_d  = poly_sel;
            s_d     = seed_fix(s_q, poly_sel);
            state_d = FILL;
          end
        end
        FILL: begin
          load    = 1'b1;
          state_d = RUN;
        end
        RUN: begin
          if (ready) begin
            load  = 1'b1;
            cnt_d = (cnt_q == '1) ?
              cnt_q : cnt_q + 32'd1;
          end
          if (!en) state_d = HOLD;
        end
        HOLD: begin
          if (en) state_d = RUN;
        end
      endcase
    end
    if (load) begin
      s_d       = s_step;
      data_d    = word_step ^ {WIDTH{invert}};
      data_d[0] = data_d[0] ^ flip;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      s_q     <= S_RST;
      poly_q  <= POLY_DEFAULT;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      poly_q  <= poly_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PRBS_ERR_INJ_EN
  logic        err_arm_q, err_arm_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  // A pulse coinciding with a load corrupts that very word.
  always_comb begin
    err_arm_d = err_arm_q | err_inject;
    err_cnt_d = err_cnt_q;
    flip      = 1'b0;
    if (load && err_arm_d) begin
      flip      = 1'b1;
      err_arm_d = 1'b0;
      err_cnt_d = (err_cnt_q == '1) ?
        err_cnt_q : err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_arm_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_arm_q <= err_arm_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign flip = 1'b0;
`endif

  assign data     = data_q;
  assign valid    = (state_q == RUN);
  assign word_cnt = cnt_q;

endmodule

// File: tb/tb_prbs_gen_multi.sv
// Directed + randomized bench for prbs_gen_multi (WIDTH=8).
// Reference: PRBS bit recurrence x[k] = x[k-N] ^ x[k-M].
module tb_prbs_gen_multi;

  localparam int W = 8;

  logic         clk;
  logic         reset_n;
  logic         en;
  logic [1:0]   poly_sel;
  logic         seed_load;
  logic [30:0]  seed;
  logic         invert;
  logic [W-1:0] data;
  logic         valid;
  logic         ready;
  logic [31:0]  word_cnt;
`ifdef PRBS_ERR_INJ_EN
  logic         err_inject;
  logic [15:0]  err_cnt;
`endif

  prbs_gen_multi #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .poly_sel  (poly_sel),
    .seed_load (seed_load),
    .seed      (seed),
    .invert    (invert),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .word_cnt  (word_cnt)
`ifdef PRBS_ERR_INJ_EN
    ,
    .err_inject (err_inject),
    .err_cnt    (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  bit hist[$];
  int tn, tm;
  logic [W-1:0] exp_w;
  logic [W-1:0] words [254];
  int ecnt;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic model_seed(input int p,
                            input logic [30:0] sd);
    int nn [4] = '{7, 15, 23, 31};
    int mm [4] = '{6, 14, 18, 28};
    longint unsigned v;
    tn = nn[p];
    tm = mm[p];
    v = longint'(sd) % (64'd1 << tn);
    if (v == 0) v = 1;
    hist.delete();
    for (int j = tn - 1; j >= 0; j--)
      hist.push_back(bit'((v >> j) & 1));
  endtask

  task automatic mw(input logic inv,
                    output logic [W-1:0] w);
    bit b;
    w = '0;
    for (int i = 0; i < W; i++) begin
      b = hist[hist.size() - tn] ^
          hist[hist.size() - tm];
      hist.push_back(b);
      if (hist.size() > 64) void'(hist.pop_front());
      w = {w[W-2:0], b};
    end
    if (inv) w = ~w;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seed(input int p,
                           input logic [30:0] sd,
                           input logic inv);
    poly_sel  = 2'(p);
    seed      = sd;
    invert    = inv;
    seed_load = 1'b1;
    step();
    seed_load = 1'b0;
    model_seed(p, sd);
    ecnt = 0;
    chk("load_valid", 64'(valid), 64'd0);
    chk("load_cnt", 64'(word_cnt), 64'd0);
  endtask

  initial begin
    logic [W-1:0] acc;
    logic rdy, inv;
    reset_n   = 1'b1;
    en        = 1'b0;
    poly_sel  = 2'd3;
    seed_load = 1'b0;
    seed      = '0;
    invert    = 1'b0;
    ready     = 1'b0;
`ifdef PRBS_ERR_INJ_EN
    err_inject = 1'b0;
`endif
    #1 reset_n = 1'b0;
    step();
    step();
    chk("rst_data", 64'(data), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_cnt", 64'(word_cnt), 64'd0);
    reset_n = 1'b1;
    step();
    chk("idle_valid", 64'(valid), 64'd0);

    // default PRBS31 from reset
    model_seed(3, 31'h7FFF_FFFF);
    en = 1'b1;
    ready = 1'b1;
    step();
    chk("fill_valid", 64'(valid), 64'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      mw(1'b0, exp_w);
      chk("p31_valid", 64'(valid), 64'd1);
      chk("p31_data", 64'(data), 64'(exp_w));
    end
    chk("p31_cnt", 64'(word_cnt), 64'd4);

    // directed PRBS7 vectors
    load_seed(0, 31'h7F, 1'b0);
    step();
    mw(1'b0, exp_w);
    chk("p7_w0", 64'(data), 64'h02);
    chk("p7_w0m", 64'(data), 64'(exp_w));
    chk("p7_valid", 64'(valid), 64'd1);
    step();
    mw(1'b0, exp_w);
    chk("p7_w1", 64'(data), 64'h0C);
    chk("p7_w1m", 64'(data), 64'(exp_w));
    chk("p7_cnt1", 64'(word_cnt), 64'd1);
    step();
    mw(1'b0, exp_w);
    chk("p7_cnt2", 64'(word_cnt), 64'd2);
    chk("p7_w2m", 64'(data), 64'(exp_w));

    load_seed(0, 31'h7F, 1'b1);
    step();
    chk("p7i_w0", 64'(data), 64'hFD);
    step();
    chk("p7i_w1", 64'(data), 64'hF3);

    // backpressure
    load_seed(2, 31'($urandom), 1'b0);
    step();
    mw(1'b0, exp_w);
    step();
    mw(1'b0, exp_w);
    ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_data", 64'(data), 64'(exp_w));
      chk("bp_valid", 64'(valid), 64'd1);
      chk("bp_cnt", 64'(word_cnt), 64'd1);
    end
    ready = 1'b1;
    step();
    mw(1'b0, exp_w);
    chk("bp_resume", 64'(data), 64'(exp_w));
    chk("bp_cnt2", 64'(word_cnt), 64'd2);

    // PRBS7 period
    load_seed(0, 31'($urandom_range(1, 127)), 1'b0);
    for (int k = 0; k < 254; k++) begin
      step();
      mw(1'b0, exp_w);
      words[k] = data;
      chk("per_model", 64'(data), 64'(exp_w));
    end
    for (int k = 0; k < 127; k++)
      chk("per7", 64'(words[k + 127]), 64'(words[k]));

    // random ready/invert/poly_sel noise, PRBS15/23
    for (int p = 1; p <= 2; p++) begin
      load_seed(p, 31'($urandom), 1'b0);
      step();
      mw(1'b0, exp_w);
      chk("rnd_first", 64'(data), 64'(exp_w));
      for (int k = 0; k < 300; k++) begin
        rdy = 1'($urandom);
        inv = 1'($urandom);
        ready = rdy;
        invert = inv;
        poly_sel = 2'($urandom);
        step();
        if (rdy) begin
          mw(inv, exp_w);
          ecnt++;
        end
        chk("rnd_data", 64'(data), 64'(exp_w));
        chk("rnd_valid", 64'(valid), 64'd1);
        chk("rnd_cnt", 64'(word_cnt), 64'(ecnt));
      end
    end
    ready = 1'b1;

    // zero seed on PRBS31: no lockup
    load_seed(3, 31'd0, 1'b0);
    acc = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      mw(1'b0, exp_w);
      acc = acc | data;
      chk("z_data", 64'(data), 64'(exp_w));
    end
    chk("z_nonzero", 64'(acc != '0), 64'd1);

    // seed_load mid-RUN, then HOLD handling
    load_seed(0, 31'h7F, 1'b0);
    step();
    mw(1'b0, exp_w);
    chk("re_w0", 64'(data), 64'h02);
    ready = 1'b0;
    en = 1'b0;
    step();
    chk("hold_valid", 64'(valid), 64'd0);
    chk("hold_data", 64'(data), 64'h02);
    step();
    chk("hold_data2", 64'(data), 64'h02);
    en = 1'b1;
    step();
    chk("unhold_valid", 64'(valid), 64'd1);
    chk("unhold_data", 64'(data), 64'h02);
    ready = 1'b1;
    step();
    mw(1'b0, exp_w);
    chk("unhold_next", 64'(data), 64'h0C);
    en = 1'b0;
    step();
    mw(1'b0, exp_w);
    chk("acc_fall_valid", 64'(valid), 64'd0);
    chk("acc_fall_data", 64'(data), 64'(exp_w));
    chk("acc_fall_cnt", 64'(word_cnt), 64'd2);
    en = 1'b1;
    step();
    chk("acc_fall_run", 64'(valid), 64'd1);
    chk("acc_fall_same", 64'(data), 64'(exp_w));

`ifdef PRBS_ERR_INJ_EN
    err_inject = 1'b1;
    step();
    err_inject = 1'b0;
    mw(1'b0, exp_w);
    chk("ei_word", 64'(data), 64'(exp_w ^ 8'h01));
    chk("ei_cnt", 64'(err_cnt), 64'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      mw(1'b0, exp_w);
      chk("ei_after", 64'(data), 64'(exp_w));
    end
    chk("ei_cnt2", 64'(err_cnt), 64'd1);
`endif

    // async reset mid-burst
    poly_sel = 2'd3;
    step();
    #3 reset_n = 1'b0;
    #1;
    chk("arst_data", 64'(data), 64'd0);
    chk("arst_valid", 64'(valid), 64'd0);
    chk("arst_cnt", 64'(word_cnt), 64'd0);
    step();
    reset_n = 1'b1;
    model_seed(3, 31'h7FFF_FFFF);
    step();
    chk("arst_fill", 64'(valid), 64'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      mw(1'b0, exp_w);
      chk("arst_seq", 64'(data), 64'(exp_w));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/prbs_gen_multi.md
Name: prbs_gen_multi

Overview:
Parametrised successor PRBS source for the BER tester TX path.
- Generates ITU-style PRBS7/15/23/31 (polynomial selectable at runtime), WIDTH bits per word, MSB-first.
- Adds seed loading, inverted mode, valid/ready backpressure and an accepted-word counter.
- Feeds the serializer/TX lane; the matching checker uses the same package constants.

Parameters:
WIDTH, 32, output word width in bits; legal range 1..64.
POLY_DEFAULT, 2'd3, polynomial after reset: 0=PRBS7, 1=PRBS15, 2=PRBS23, 3=PRBS31.
SEED_DEFAULT, 31'h7FFF_FFFF, LFSR seed after reset, masked to polynomial length.

Ports:
clk  input  1  clock, all logic on rising edge.
reset_n  input  1  asynchronous active-low reset.
en  input  1  run enable.
poly_sel  input  2  polynomial select; sampled only in IDLE or on seed_load.
seed_load  input  1  one-cycle pulse that loads seed.
seed  input  31  seed value; LSBs used for shorter polynomials.
invert  input  1  output inversion, sampled when each word is computed.
data  output  WIDTH  PRBS word.
valid  output  1  data valid.
ready  input  1  downstream accept.
word_cnt  output  32  count of accepted words.
err_inject  input  1  present only with PRBS_ERR_INJ_EN.
err_cnt  output  16  present only with PRBS_ERR_INJ_EN.

Behaviour:
- LFSR state s[30:0]. For PRBS-N with taps (N,M) = (7,6), (15,14), (23,18) or (31,28), one serial step is:
  - fb = s[N-1]^s[M-1]
  - s[N-1:0] <= {s[N-2:0], fb}
  - output bit = fb
- Each word advances WIDTH serial steps in one cycle. The first generated bit goes to data[WIDTH-1]. Bits of s at N and above are held at 0.
- Reset (async, reset_n=0):
  - s = SEED_DEFAULT masked to the polynomial length; poly_q = POLY_DEFAULT.
  - data = 0, valid = 0, word_cnt = 0, err_cnt = 0, state = IDLE.
- FSM states:
  - IDLE: valid=0. If en=1, latch poly_sel and go to FILL.
  - FILL: compute the word into data (inverted if invert=1), advance s, go to RUN. valid rises the cycle after FILL, so first data arrives 2 cycles after en rises.
  - RUN: valid=1. On valid&&ready, load the next word, advance s and increment word_cnt; valid stays 1, giving one word per cycle under continuous ready. If valid&&!ready, data and s hold.
  - HOLD: entered from RUN when en=0 at a non-accept edge. valid=0, data and s held. en=1 returns to RUN with the same data; no word is lost.
- If en falls on an accept edge, the transfer completes: the next word is loaded, then the FSM enters HOLD.
- seed_load in any state (priority over everything else):
  - s <= seed masked to the polynomial length; a zero masked seed loads 1.
  - poly_q <= poly_sel, word_cnt <= 0, valid <= 0.
  - Next state is FILL if en=1, else IDLE.
- poly_sel changes in FILL, RUN or HOLD are ignored.
- word_cnt saturates at 32'hFFFF_FFFF.
- Reset mid-operation forces reset values immediately, regardless of any handshake in progress.

Optional Feature:
PRBS_ERR_INJ_EN
- Defined:
  - An err_inject pulse arms a flag; the flag stays armed across cycles until consumed.
  - The next word loaded into data has data[0] flipped. The LFSR state is not affected, so the sequence stays aligned.
  - The flag clears when that word is loaded; err_cnt increments and saturates.
  - Multiple pulses before consumption count as one.
- Undefined: err_inject and err_cnt ports are absent; data is pure PRBS.

Decomposition:
- Package prbs_pkg holds:
  - poly_sel encodings: POLY_PRBS7/15/23/31.
  - Tap table: N and M per polynomial.
  - Length masks.
  - The FSM state typedef (IDLE, FILL, RUN, HOLD).
- Sub-module prbs_wide_step (combinational), shared with the checker:
  - Inputs: state, poly.
  - Outputs: next state after WIDTH steps, and the WIDTH-bit word.

Test Plan:
- WIDTH=8, seed_load with poly_sel=0, seed=7'h7F, en=1, ready=1:
  - data words 8'h02 then 8'h0C; valid first high 2 cycles after load; word_cnt=2 after two accepts.
  - Same stimulus with invert=1: 8'hFD, 8'hF3.
- PRBS7, WIDTH=8: word k+127 equals word k for all k<127 (period check); repeat for PRBS15 against the reference model.
- ready held 0 for 5 cycles in RUN: data stable, valid=1, word_cnt unchanged; ready=1 resumes with the next word in sequence.
- seed=0 with poly_sel=3: LFSR loads 1, output is non-zero within 31 bits, no lockup. seed_load mid-RUN: valid drops, then the sequence restarts from the new seed.
- reset_n pulled low asynchronously mid-burst: data=0, valid=0 and word_cnt=0 immediately; after release, the PRBS31 default sequence restarts.
- With PRBS_ERR_INJ_EN: err_inject pulse gives exactly one word differing in bit 0 from the golden model, the following words match, and err_cnt=1.
